// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory and holds resetpc low until the image is complete.
// One write cycle per word (5 cycles/word at full rate); s_ready drops during WRITE so the source holds its byte.
module imem_loader #(
   parameter int MAX_WORDS = 128,
   parameter int ADDR_W    = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              we0,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [31:0]       wr_din0,
   output logic              resetpc,
   output logic              load_done,
   output logic              load_err,
   output logic [7:0]        words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

   state_t              r_state, w_state_nxt;
   logic [7:0]          r_n, w_n_nxt;
   logic [7:0]          r_words, w_words_nxt;
   logic [1:0]          r_byte_idx, w_byte_idx_nxt;
   logic [31:0]         r_asm, w_asm_nxt;
   logic                r_we0, w_we0_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [31:0]         r_din, w_din_nxt;
   logic                r_resetpc, w_resetpc_nxt;
   logic                r_done, w_done_nxt;
   logic                r_err, w_err_nxt;
   logic                w_accept;
   logic [7:0]          w_words_inc;
   logic [ADDR_W-1:0]   w_word_addr;

   assign s_ready      = (r_state == S_HDR) || (r_state == S_DATA);
   assign w_accept     = s_valid && s_ready;
   assign w_words_inc  = r_words + 8'd1;
   // The written-word count doubles as the index of the word being assembled.
   assign w_word_addr  = ADDR_W'(r_words) << 2;

   assign we0          = r_we0;
   assign wr_addr0     = r_addr;
   assign wr_din0      = r_din;
   assign resetpc      = r_resetpc;
   assign load_done    = r_done;
   assign load_err     = r_err;
   assign words_loaded = r_words;

   always_comb begin
      w_state_nxt    = r_state;
      w_n_nxt        = r_n;
      w_words_nxt    = r_words;
      w_byte_idx_nxt = r_byte_idx;
      w_asm_nxt      = r_asm;
      w_we0_nxt      = 1'b0;
      w_addr_nxt     = r_addr;
      w_din_nxt      = r_din;
      w_resetpc_nxt  = r_resetpc;
      w_done_nxt     = r_done;
      w_err_nxt      = r_err;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_HDR;
               w_err_nxt   = 1'b0;
               w_words_nxt = 8'd0;
            end
         end
         S_HDR: begin
            if (w_accept) begin
               if (s_data == 8'd0 || s_data > MAX_N) begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_n_nxt        = s_data;
                  w_byte_idx_nxt = 2'd0;
                  w_words_nxt    = 8'd0;
                  w_state_nxt    = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (w_accept) begin
               w_asm_nxt[{r_byte_idx, 3'b000} +: 8] = s_data;
               w_byte_idx_nxt = r_byte_idx + 2'd1;
               if (r_byte_idx == 2'd3) begin
                  w_we0_nxt   = 1'b1;
                  w_addr_nxt  = w_word_addr;
                  w_din_nxt   = w_asm_nxt;
                  w_state_nxt = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            w_words_nxt = w_words_inc;
            // Release the core on the same edge that commits the last word.
            if (w_words_inc == r_n) begin
               w_resetpc_nxt = 1'b1;
               w_done_nxt    = 1'b1;
               w_state_nxt   = S_DONE;
            end else begin
               w_state_nxt = S_DATA;
            end
         end
         S_DONE: begin
            if (start) begin
               w_resetpc_nxt = 1'b0;
               w_done_nxt    = 1'b0;
               w_err_nxt     = 1'b0;
               w_words_nxt   = 8'd0;
               w_state_nxt   = S_HDR;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_n        <= 8'd0;
         r_words    <= 8'd0;
         r_byte_idx <= 2'd0;
         r_asm      <= 32'd0;
         r_we0      <= 1'b0;
         r_addr     <= '0;
         r_din      <= 32'd0;
         r_resetpc  <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_n        <= w_n_nxt;
         r_words    <= w_words_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_asm      <= w_asm_nxt;
         r_we0      <= w_we0_nxt;
         r_addr     <= w_addr_nxt;
         r_din      <= w_din_nxt;
         r_resetpc  <= w_resetpc_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
      end
   end

endmodule
